// File: rtl/sseg_scan_decoder.sv
// Rebuilds the eight hex digits and decimal points from the scanned anode/segment
// lines of the two 4-digit displays, with frame, glyph-error and stall status.
module sseg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  D1_AN,
  input  logic [3:0]  D2_AN,
  input  logic [7:0]  D1_SEG,
  input  logic [7:0]  D2_SEG,
  output logic [31:0] hex_digits,
  output logic [7:0]  dpoints,
  output logic [7:0]  digit_valid,
  output logic [7:0]  pattern_err,
  output logic        frame_done,
  output logic        stalled
);

  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_MAX    = IW'(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] IDLE_LAST   = IW'(TIMEOUT_CYCLES - 1);

  // Line vector layout: {D1_AN, D2_AN, D1_SEG, D2_SEG}
  logic [23:0]   sync1_reg, v_reg, prev_reg;
  logic [SW-1:0] settle_reg;
  logic          captured_reg;
  logic          capture_fire;

  logic [31:0]   hex_reg, hex_next;
  logic [7:0]    dp_reg, dp_next;
  logic [7:0]    valid_reg, valid_next;
  logic [7:0]    err_reg, err_next;
  logic [3:0]    seen_reg, seen_next;
  logic [IW-1:0] idle_reg, idle_next;
  logic          frame_reg, frame_next;
  logic          stalled_reg, stalled_next;

  logic          an_ok;
  logic [1:0]    slot;
  logic [3:0]    slot_onehot;
  logic          qual_cap;

  logic [1:0]    dec_hit;
  logic [1:0]    dec_dp;
  logic [3:0]    dec_val [2];

  // Returns {hit, value}; hit is 0 for any pattern outside the hex glyph set.
  function automatic logic [4:0] glyph_decode(input logic [6:0] p);
    logic [4:0] r;
    r = 5'b0;
    case (p)
      7'h3F: r = {1'b1, 4'h0};
      7'h06: r = {1'b1, 4'h1};
      7'h5B: r = {1'b1, 4'h2};
      7'h4F: r = {1'b1, 4'h3};
      7'h66: r = {1'b1, 4'h4};
      7'h6D: r = {1'b1, 4'h5};
      7'h7D: r = {1'b1, 4'h6};
      7'h07: r = {1'b1, 4'h7};
      7'h7F: r = {1'b1, 4'h8};
      7'h6F: r = {1'b1, 4'h9};
      7'h77: r = {1'b1, 4'hA};
      7'h7C: r = {1'b1, 4'hB};
      7'h39: r = {1'b1, 4'hC};
      7'h5E: r = {1'b1, 4'hD};
      7'h79: r = {1'b1, 4'hE};
      7'h71: r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg    <= '1;
      v_reg        <= '1;
      prev_reg     <= '1;
      settle_reg   <= '0;
      captured_reg <= 1'b0;
    end else begin
      sync1_reg <= {D1_AN, D2_AN, D1_SEG, D2_SEG};
      v_reg     <= sync1_reg;
      prev_reg  <= v_reg;
      if (v_reg != prev_reg) begin
        settle_reg   <= '0;
        captured_reg <= 1'b0;
      end else begin
        if (settle_reg != SETTLE_LAST) settle_reg <= settle_reg + 1'b1;
        if (capture_fire) captured_reg <= 1'b1;
      end
    end
  end

  // A changing vector on the capture cycle must not be sampled mid-transition.
  assign capture_fire = (v_reg == prev_reg) && (settle_reg == SETTLE_LAST) && !captured_reg;

  always_comb begin
    an_ok = 1'b0;
    slot  = 2'd0;
    if (v_reg[23:20] == v_reg[19:16]) begin
      case (v_reg[19:16])
        4'b1110: begin an_ok = 1'b1; slot = 2'd0; end
        4'b1101: begin an_ok = 1'b1; slot = 2'd1; end
        4'b1011: begin an_ok = 1'b1; slot = 2'd2; end
        4'b0111: begin an_ok = 1'b1; slot = 2'd3; end
        default: begin an_ok = 1'b0; slot = 2'd0; end
      endcase
    end
  end

  assign slot_onehot = 4'b0001 << slot;
  assign qual_cap    = capture_fire && an_ok;

  // Display index 0 is D2 (digits 0-3), index 1 is D1 (digits 4-7).
  for (genvar gi = 0; gi < 2; gi++) begin : g_disp
    logic [7:0] seg;
    logic [4:0] dec;
    assign seg         = v_reg[8*gi +: 8];
    assign dec         = glyph_decode(~seg[6:0]);
    assign dec_hit[gi] = dec[4];
    assign dec_val[gi] = dec[3:0];
    assign dec_dp[gi]  = ~seg[7];
  end

  always_comb begin
    hex_next     = hex_reg;
    dp_next      = dp_reg;
    valid_next   = valid_reg;
    err_next     = err_reg;
    seen_next    = seen_reg;
    idle_next    = idle_reg;
    frame_next   = 1'b0;
    stalled_next = stalled_reg;
    if (qual_cap) begin
      for (int d = 0; d < 2; d++) begin
        dp_next[{d[0], slot}] = dec_dp[d];
        if (dec_hit[d]) begin
          hex_next[{d[0], slot, 2'b00} +: 4] = dec_val[d];
          valid_next[{d[0], slot}]           = 1'b1;
          err_next[{d[0], slot}]             = 1'b0;
        end else begin
          valid_next[{d[0], slot}] = 1'b0;
          err_next[{d[0], slot}]   = 1'b1;
        end
      end
      if ((seen_reg | slot_onehot) == 4'hF) begin
        frame_next = 1'b1;
        seen_next  = 4'h0;
      end else begin
        seen_next = seen_reg | slot_onehot;
      end
      stalled_next = 1'b0;
      idle_next    = '0;
    end else if (idle_reg != IDLE_MAX) begin
      idle_next = idle_reg + 1'b1;
      // Stall drops validity but keeps the last digits visible for diagnosis.
      if (idle_reg == IDLE_LAST) begin
        stalled_next = 1'b1;
        valid_next   = 8'h00;
        seen_next    = 4'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hex_reg     <= '0;
      dp_reg      <= '0;
      valid_reg   <= '0;
      err_reg     <= '0;
      seen_reg    <= '0;
      idle_reg    <= '0;
      frame_reg   <= 1'b0;
      stalled_reg <= 1'b0;
    end else begin
      hex_reg     <= hex_next;
      dp_reg      <= dp_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      seen_reg    <= seen_next;
      idle_reg    <= idle_next;
      frame_reg   <= frame_next;
      stalled_reg <= stalled_next;
    end
  end

  assign hex_digits  = hex_reg;
  assign dpoints     = dp_reg;
  assign digit_valid = valid_reg;
  assign pattern_err = err_reg;
  assign frame_done  = frame_reg;
  assign stalled     = stalled_reg;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: vector table, hand-written timing sequences and a
// randomized run against a digit-array reference model.
module tb_sseg_scan_decoder;

  localparam int S  = 16;
  localparam int TO = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  d1_an = 4'hF, d2_an = 4'hF;
  logic [7:0]  d1_seg = 8'hFF, d2_seg = 8'hFF;
  logic [31:0] hex_digits;
  logic [7:0]  dpoints, digit_valid, pattern_err;
  logic        frame_done, stalled;

  int n_checks = 0;
  int n_pass   = 0;
  int frame_cnt = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  typedef struct {
    logic [3:0]  an1, an2;
    logic [7:0]  s1, s2;
    logic [31:0] hex;
    logic [7:0]  dp, valid, err;
    int          frames;
  } vec_t;
  vec_t vecs [6];

  // Reference model state
  logic [3:0] m_hex [8];
  logic [7:0] m_dp, m_valid, m_err;
  logic [3:0] m_seen;

  sseg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .D1_AN(d1_an), .D2_AN(d2_an), .D1_SEG(d1_seg), .D2_SEG(d2_seg),
    .hex_digits(hex_digits), .dpoints(dpoints), .digit_valid(digit_valid),
    .pattern_err(pattern_err), .frame_done(frame_done), .stalled(stalled)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_done === 1'b1) frame_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n, input logic dp);
    return {~dp, ~glyph[n]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] a1, input logic [3:0] a2,
                       input logic [7:0] s1, input logic [7:0] s2);
    d1_an = a1; d2_an = a2; d1_seg = s1; d2_seg = s2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(4'hF, 4'hF, 8'hFF, 8'hFF);
    tick(3);
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic rotate_slot(input int k, input int hold);
    logic [3:0] an;
    an = ~(4'b0001 << k);
    drive(an, an, seg_of(4'(k + 5), 1'b0), seg_of(4'(k + 1), 1'b0));
    tick(hold);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_hex[i] = 4'h0;
    m_dp = 8'h0; m_valid = 8'h0; m_err = 8'h0; m_seen = 4'h0;
  endtask

  // Applies one stable pattern to the model; reports whether it was a qualified capture.
  task automatic model_apply(input logic [3:0] a1, input logic [3:0] a2,
                             input logic [7:0] s1, input logic [7:0] s2,
                             output int qualified, output int frames);
    int zeros, k, idx, found;
    logic [7:0] sg;
    qualified = 0; frames = 0; zeros = 0; k = 0;
    for (int b = 0; b < 4; b++) if (a2[b] == 1'b0) begin zeros++; k = b; end
    if (a1 != a2 || zeros != 1) return;
    qualified = 1;
    for (int d = 0; d < 2; d++) begin
      sg = (d == 0) ? s2 : s1;
      idx = k + 4 * d;
      m_dp[idx] = ~sg[7];
      found = -1;
      for (int g = 0; g < 16; g++) if (glyph[g] == ~sg[6:0]) found = g;
      if (found >= 0) begin
        m_hex[idx] = 4'(found); m_valid[idx] = 1'b1; m_err[idx] = 1'b0;
      end else begin
        m_valid[idx] = 1'b0; m_err[idx] = 1'b1;
      end
    end
    m_seen[k] = 1'b1;
    if (m_seen == 4'hF) begin frames = 1; m_seen = 4'h0; end
  endtask

  function automatic logic [31:0] m_hex_word();
    logic [31:0] w;
    for (int i = 0; i < 8; i++) w[4*i +: 4] = m_hex[i];
    return w;
  endfunction

  initial begin
    int base, q, fr, unq, r, k;
    logic [3:0] a1, a2;
    logic [7:0] s1, s2;
    logic [23:0] last_pat;

    // Reset state
    do_reset();
    check("reset_hex", hex_digits, 32'h0);
    check("reset_dp", {24'h0, dpoints}, 32'h0);
    check("reset_valid", {24'h0, digit_valid}, 32'h0);
    check("reset_err", {24'h0, pattern_err}, 32'h0);
    check("reset_flags", {30'h0, frame_done, stalled}, 32'h0);

    // Table: cumulative outputs after each held pattern
    vecs[0] = '{4'hE, 4'hE, 8'h08, 8'h92, 32'h000A0005, 8'h10, 8'h11, 8'h00, 0};
    vecs[1] = '{4'hD, 4'hD, seg_of(4'h2, 1'b0), seg_of(4'h1, 1'b0),
                32'h002A0015, 8'h10, 8'h33, 8'h00, 0};
    vecs[2] = '{4'hE, 4'hD, seg_of(4'h9, 1'b1), seg_of(4'h9, 1'b1),
                32'h002A0015, 8'h10, 8'h33, 8'h00, 0};
    vecs[3] = '{4'hC, 4'hC, seg_of(4'h8, 1'b1), seg_of(4'h8, 1'b1),
                32'h002A0015, 8'h10, 8'h33, 8'h00, 0};
    vecs[4] = '{4'hB, 4'hB, seg_of(4'h3, 1'b0), 8'hFF,
                32'h032A0015, 8'h10, 8'h73, 8'h04, 0};
    vecs[5] = '{4'h7, 4'h7, seg_of(4'hC, 1'b0), seg_of(4'hF, 1'b1),
                32'hC32AF015, 8'h18, 8'hFB, 8'h04, 1};
    for (int i = 0; i < 6; i++) begin
      base = frame_cnt;
      drive(vecs[i].an1, vecs[i].an2, vecs[i].s1, vecs[i].s2);
      tick(25);
      check($sformatf("vec%0d_hex", i), hex_digits, vecs[i].hex);
      check($sformatf("vec%0d_dp", i), {24'h0, dpoints}, {24'h0, vecs[i].dp});
      check($sformatf("vec%0d_valid", i), {24'h0, digit_valid}, {24'h0, vecs[i].valid});
      check($sformatf("vec%0d_err", i), {24'h0, pattern_err}, {24'h0, vecs[i].err});
      check($sformatf("vec%0d_frames", i), frame_cnt - base, vecs[i].frames);
    end

    // Exact capture latency
    do_reset();
    drive(4'hE, 4'hE, 8'h08, 8'h92);
    tick(S + 2);
    check("lat_before", hex_digits, 32'h0);
    tick(1);
    check("lat_hex", hex_digits, 32'h000A0005);
    check("lat_valid", {24'h0, digit_valid}, 32'h11);
    check("lat_frame", {31'h0, frame_done}, 32'h0);

    // Short glitch to blank segments must not be captured
    drive(4'hE, 4'hE, 8'h08, seg_of(4'h7, 1'b0));
    tick(25);
    check("glitch_pre", {28'h0, hex_digits[3:0]}, 32'h7);
    drive(4'hE, 4'hE, 8'h08, 8'h92); tick(3);
    drive(4'hE, 4'hE, 8'h08, 8'hFF); tick(5);
    drive(4'hE, 4'hE, 8'h08, 8'h92);
    tick(S + 2);
    check("glitch_hold", {28'h0, hex_digits[3:0]}, 32'h7);
    check("glitch_no_err", {31'h0, pattern_err[0]}, 32'h0);
    tick(1);
    check("glitch_recap", {28'h0, hex_digits[3:0]}, 32'h5);

    // Two full rotations
    do_reset();
    base = frame_cnt;
    for (int s = 0; s < 4; s++) rotate_slot(s, 40);
    check("rot1_hex", hex_digits, 32'h87654321);
    check("rot1_valid", {24'h0, digit_valid}, 32'hFF);
    check("rot1_frames", frame_cnt - base, 1);
    for (int s = 0; s < 4; s++) rotate_slot(s, 40);
    check("rot2_frames", frame_cnt - base, 2);

    // Stall on blank display, then recovery
    drive(4'hF, 4'hF, 8'hFF, 8'hFF);
    tick(900);
    check("stall_early", {31'h0, stalled}, 32'h0);
    tick(100);
    check("stall_set", {31'h0, stalled}, 32'h1);
    check("stall_valid", {24'h0, digit_valid}, 32'h0);
    check("stall_hex", hex_digits, 32'h87654321);
    drive(4'hE, 4'hE, seg_of(4'h0, 1'b0), seg_of(4'h9, 1'b0));
    tick(S + 2);
    check("stall_hold", {31'h0, stalled}, 32'h1);
    tick(1);
    check("stall_clear", {31'h0, stalled}, 32'h0);
    check("stall_rcv_valid", {24'h0, digit_valid}, 32'h11);
    check("stall_rcv_hex", hex_digits, 32'h87604329);

    // Asynchronous reset mid-rotation
    do_reset();
    rotate_slot(0, 40);
    rotate_slot(1, 40);
    rotate_slot(2, 10);
    reset_n = 1'b0;
    #1;
    check("arst_hex", hex_digits, 32'h0);
    check("arst_misc", {dpoints, digit_valid, pattern_err, 6'h0, frame_done, stalled}, 32'h0);
    tick(3);
    reset_n = 1'b1;
    base = frame_cnt;
    tick(40);
    rotate_slot(3, 40);
    rotate_slot(0, 40);
    check("arst_no_frame", frame_cnt - base, 0);
    rotate_slot(1, 40);
    check("arst_frame", frame_cnt - base, 1);

    // Randomized patterns against the reference model
    do_reset();
    model_reset();
    last_pat = 24'hFFFFFF;
    unq = 0;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 15 && unq < 8) begin
        a1 = 4'($urandom); a2 = 4'($urandom);
      end else begin
        k = $urandom_range(0, 3);
        a1 = ~(4'b0001 << k); a2 = a1;
      end
      s1 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : seg_of(4'($urandom), 1'($urandom));
      s2 = ($urandom_range(0, 4) == 0) ? 8'($urandom) : seg_of(4'($urandom), 1'($urandom));
      q = 0; fr = 0;
      if ({a1, a2, s1, s2} != last_pat) model_apply(a1, a2, s1, s2, q, fr);
      last_pat = {a1, a2, s1, s2};
      unq = q ? 0 : unq + 1;
      base = frame_cnt;
      drive(a1, a2, s1, s2);
      tick(25);
      check($sformatf("rnd%0d_hex", i), hex_digits, m_hex_word());
      check($sformatf("rnd%0d_dp", i), {24'h0, dpoints}, {24'h0, m_dp});
      check($sformatf("rnd%0d_valid", i), {24'h0, digit_valid}, {24'h0, m_valid});
      check($sformatf("rnd%0d_err", i), {24'h0, pattern_err}, {24'h0, m_err});
      check($sformatf("rnd%0d_frames", i), frame_cnt - base, fr);
      check($sformatf("rnd%0d_stalled", i), {31'h0, stalled}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
